// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } tx_arb_state_t;

  localparam logic [3:0] HEADER_TAG = 4'hA;
  localparam int         MAX_SRC    = 16;

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Round-robin picker: rotate requests so rr_ptr sits at bit 0, take the lowest
// set bit, then rotate the index back into source numbering.
module rr_picker
  import tx_arb_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]      req,
  input  logic [SRC_ID_WIDTH-1:0] rr_ptr,
  output logic                    pick_valid,
  output logic [SRC_ID_WIDTH-1:0] pick_id
);

  localparam logic [SRC_ID_WIDTH:0] L_NUM_SRC = (SRC_ID_WIDTH + 1)'(NUM_SRC);

  logic [NUM_SRC-1:0]      w_rot;
  logic [SRC_ID_WIDTH-1:0] w_idx;
  logic [SRC_ID_WIDTH:0]   w_sum;

  // Rotate, priority-encode (lowest index wins), unrotate modulo NUM_SRC.
  always_comb begin
    w_rot = NUM_SRC'({req, req} >> rr_ptr);
    w_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      w_idx = w_rot[i] ? SRC_ID_WIDTH'(i) : w_idx;
    end
    w_sum      = {1'b0, rr_ptr} + {1'b0, w_idx};
    pick_valid = |req;
    pick_id    = (w_sum >= L_NUM_SRC) ? SRC_ID_WIDTH'(w_sum - L_NUM_SRC)
                                      : w_sum[SRC_ID_WIDTH-1:0];
  end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-atomic round-robin arbiter in front of the UART TX FIFO write port.
// Define TX_ARB_HEADER_EN to prefix each packet with a source-ID header byte.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter  int NUM_SRC      = 4,
  parameter  int DATA_WIDTH   = 8,
  localparam int SRC_ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [SRC_ID_WIDTH-1:0]       grant_id
);

  tx_arb_state_t           r_state;
  tx_arb_state_t           w_next_state;
  logic [SRC_ID_WIDTH-1:0] r_grant_id;
  logic                    r_grant_valid;
  logic [SRC_ID_WIDTH-1:0] r_rr_ptr;
  logic                    w_pick_valid;
  logic [SRC_ID_WIDTH-1:0] w_pick_id;
  logic                    w_g_valid;
  logic                    w_g_last;
  logic [DATA_WIDTH-1:0]   w_g_data;
  logic                    w_xfer_last;
  logic [SRC_ID_WIDTH-1:0] w_ptr_next;

`ifdef TX_ARB_HEADER_EN
  function automatic logic [DATA_WIDTH-1:0] hdr_byte(input logic [SRC_ID_WIDTH-1:0] id);
    logic [DATA_WIDTH-1:0] b;
    b                     = '0;
    b[DATA_WIDTH-1 -: 4]  = HEADER_TAG;
    b[SRC_ID_WIDTH-1:0]   = id;
    return b;
  endfunction
`endif

  rr_picker #(
    .NUM_SRC      (NUM_SRC),
    .SRC_ID_WIDTH (SRC_ID_WIDTH)
  ) u_picker (
    .req        (src_valid),
    .rr_ptr     (r_rr_ptr),
    .pick_valid (w_pick_valid),
    .pick_id    (w_pick_id)
  );

  assign w_g_valid   = src_valid[r_grant_id];
  assign w_g_last    = src_last[r_grant_id];
  assign w_xfer_last = (r_state == DATA) && w_g_valid && !fifo_full && w_g_last;
  assign w_ptr_next  = (r_grant_id == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0
                                                                  : r_grant_id + SRC_ID_WIDTH'(1);
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;

  // Granted source's byte, selected without touching any control path.
  always_comb begin
    w_g_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_g_data = (r_grant_id == SRC_ID_WIDTH'(i)) ? src_data[i*DATA_WIDTH +: DATA_WIDTH] : w_g_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant bookkeeping; rr_ptr only advances once a packet fully drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_rr_ptr      <= '0;
    end else if ((r_state == IDLE) && w_pick_valid) begin
      r_grant_id    <= w_pick_id;
      r_grant_valid <= 1'b1;
    end else if (w_xfer_last) begin
      r_grant_valid <= 1'b0;
      r_rr_ptr      <= w_ptr_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
`ifdef TX_ARB_HEADER_EN
          w_next_state = HDR;
`else
          w_next_state = DATA;
`endif
        end else begin
          w_next_state = IDLE;
        end
      end
`ifdef TX_ARB_HEADER_EN
      HDR: begin
        if (!fifo_full) begin
          w_next_state = DATA;
        end else begin
          w_next_state = HDR;
        end
      end
`endif
      DATA: begin
        if (w_xfer_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DATA;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic; full stalls both ready and write in the same cycle.
  always_comb begin
    src_ready   = '0;
    fifo_we     = 1'b0;
    fifo_w_data = '0;
    case (r_state)
      IDLE: begin
        src_ready   = '0;
        fifo_we     = 1'b0;
        fifo_w_data = '0;
      end
`ifdef TX_ARB_HEADER_EN
      HDR: begin
        fifo_we     = !fifo_full;
        fifo_w_data = hdr_byte(r_grant_id);
      end
`endif
      DATA: begin
        src_ready[r_grant_id] = !fifo_full;
        fifo_we               = w_g_valid && !fifo_full;
        fifo_w_data           = w_g_data;
      end
      default: begin
        src_ready   = '0;
        fifo_we     = 1'b0;
        fifo_w_data = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a rule-level reference model.
module tb_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef TX_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_valid, src_last, src_ready;
  logic [N*DW-1:0] src_data;
  logic          fifo_we, fifo_full, grant_valid;
  logic [DW-1:0] fifo_w_data;
  logic [1:0]    grant_id;

  tx_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .fifo_we     (fifo_we),
    .fifo_w_data (fifo_w_data),
    .fifo_full   (fifo_full),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Producer state: bytes left in current packet, length of a queued follow-on packet.
  int         pend_len[N];
  int         more_len[N];
  logic [7:0] nxt_byte[N];
  bit         gap[N];
  bit         full_force, rnd_mode, chk_en;

  // Reference model: who owns the link, whether the header is still owed, where the scan starts.
  bit m_busy, m_hdr;
  int m_gid, m_ptr;

  logic       h_we[$];
  logic [7:0] h_data[$];
  logic       h_gv[$];
  logic [1:0] h_gid[$];
  logic [3:0] h_rdy[$];
  logic [7:0] exp_q[$];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int e_rdy, e_we, e_data;
    e_rdy  = 0;
    e_we   = 0;
    e_data = 0;
    if (m_busy && m_hdr) begin
      e_we   = fifo_full ? 0 : 1;
      e_data = 32'hA0 + m_gid;
    end else if (m_busy) begin
      e_rdy  = fifo_full ? 0 : (1 << m_gid);
      e_we   = (src_valid[m_gid] && !fifo_full) ? 1 : 0;
      e_data = int'(src_data[m_gid*DW +: DW]);
    end
    chk("ready", int'(src_ready), e_rdy);
    chk("we", int'(fifo_we), e_we);
    chk("wdata", int'(fifo_w_data), e_data);
    chk("gvalid", int'(grant_valid), int'(m_busy));
    chk("gid", int'(grant_id), m_gid);
  endtask

  task automatic model_advance();
    if (rst) begin
      m_busy = 1'b0; m_hdr = 1'b0; m_gid = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && src_valid[(m_ptr + k) % N]) begin
          m_busy = 1'b1;
          m_gid  = (m_ptr + k) % N;
          m_hdr  = HDR_EN;
        end
      end
    end else if (m_hdr) begin
      if (!fifo_full) m_hdr = 1'b0;
    end else if (src_valid[m_gid] && !fifo_full && src_last[m_gid]) begin
      m_busy = 1'b0;
      m_ptr  = (m_gid + 1) % N;
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      src_valid[i] = (pend_len[i] != 0) && !gap[i] && (!rnd_mode || ($urandom_range(0, 99) < 75));
      src_data[i*DW +: DW] = nxt_byte[i];
      src_last[i] = (pend_len[i] == 1);
    end
    fifo_full = full_force || (rnd_mode && ($urandom_range(0, 99) < 15));
    #1;
    if (chk_en) model_check();
    h_we.push_back(fifo_we);
    h_data.push_back(fifo_w_data);
    h_gv.push_back(grant_valid);
    h_gid.push_back(grant_id);
    h_rdy.push_back(src_ready);
    acc = src_valid & src_ready;
    model_advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        nxt_byte[i] = nxt_byte[i] + 8'd1;
        pend_len[i] = pend_len[i] - 1;
        if (pend_len[i] == 0) begin
          pend_len[i] = more_len[i];
          more_len[i] = 0;
        end
      end
      if (rst) begin
        pend_len[i] = 0;
        more_len[i] = 0;
      end
    end
  endtask

  task automatic clr();
    h_we.delete(); h_data.delete(); h_gv.delete(); h_gid.delete(); h_rdy.delete();
    exp_q.delete();
  endtask

  task automatic ex_hdr(int id);
    if (HDR_EN) exp_q.push_back(8'(32'hA0 + id));
  endtask

  task automatic ex_b(logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic chk_seq(string name);
    int n;
    n = 0;
    for (int i = 0; i < h_we.size(); i++) begin
      if (h_we[i]) begin
        if (n < exp_q.size()) chk(name, int'(h_data[i]), int'(exp_q[n]));
        n++;
      end
    end
    chk({name, "_count"}, n, exp_q.size());
  endtask

  task automatic run_until_write(logic [7:0] b, string name);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      step();
      if (h_we[$] && (h_data[$] == b)) found = 1'b1;
    end
    chk({name, "_seen"}, int'(found), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(string name);
    chk({name, "_we"}, int'(fifo_we), 0);
    chk({name, "_wdata"}, int'(fifo_w_data), 0);
    chk({name, "_ready"}, int'(src_ready), 0);
    chk({name, "_gvalid"}, int'(grant_valid), 0);
    chk({name, "_gid"}, int'(grant_id), 0);
  endtask

  initial begin
    int idx, w0;
    bit got3;
    for (int i = 0; i < N; i++) begin
      pend_len[i] = 0; more_len[i] = 0; nxt_byte[i] = 8'h00; gap[i] = 1'b0;
    end
    src_valid = '0; src_last = '0; src_data = '0; fifo_full = 1'b0;
    full_force = 1'b0; rnd_mode = 1'b0; chk_en = 1'b0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Lone request from source 1.
    clr();
    pend_len[1] = 3; nxt_byte[1] = 8'h11;
    repeat (7) step();
    ex_hdr(1); ex_b(8'h11); ex_b(8'h12); ex_b(8'h13);
    chk_seq("lone");
    idx = -1; w0 = -1;
    for (int i = 0; i < h_we.size(); i++) begin
      if (h_we[i] && (w0 < 0)) w0 = i;
      if (h_we[i] && (h_data[i] == 8'h13)) idx = i;
    end
    chk("lone_last_found", int'((idx >= 0) && (idx + 1 < h_we.size())), 1);
    if ((idx >= 0) && (idx + 1 < h_we.size())) begin
      chk("lone_consecutive", idx - w0, exp_q.size() - 1);
      chk("lone_gv_hold", int'(h_gv[idx]), 1);
      chk("lone_gv_fall", int'(h_gv[idx + 1]), 0);
    end

    // All four sources at once from reset.
    do_reset();
    clr();
    for (int i = 0; i < N; i++) begin
      pend_len[i] = 2;
      nxt_byte[i] = 8'(8'h20 + 16 * i);
    end
    repeat (20) step();
    for (int i = 0; i < N; i++) begin
      ex_hdr(i); ex_b(8'(8'h20 + 16 * i)); ex_b(8'(8'h21 + 16 * i));
    end
    chk_seq("all_src");

    // Source 3 finishes while 0 and 3 both request: 0 must win after the wrap.
    clr();
    pend_len[2] = 1; nxt_byte[2] = 8'h70;
    pend_len[3] = 2; nxt_byte[3] = 8'h80; more_len[3] = 1;
    got3 = 1'b0;
    for (int t = 0; t < 20 && !got3; t++) begin
      step();
      if (h_gv[$] && (h_gid[$] == 2'd3)) got3 = 1'b1;
    end
    chk("rr_src3_granted", int'(got3), 1);
    pend_len[0] = 1; nxt_byte[0] = 8'h90;
    repeat (12) step();
    ex_hdr(2); ex_b(8'h70); ex_hdr(3); ex_b(8'h80); ex_b(8'h81);
    ex_hdr(0); ex_b(8'h90); ex_hdr(3); ex_b(8'h82);
    chk_seq("rr_fair");

    // FIFO full for 5 cycles mid-packet.
    clr();
    pend_len[1] = 4; nxt_byte[1] = 8'h40;
    run_until_write(8'h40, "stall");
    full_force = 1'b1;
    repeat (5) step();
    for (int i = h_we.size() - 5; i < h_we.size(); i++) begin
      chk("stall_we", int'(h_we[i]), 0);
      chk("stall_ready", int'(h_rdy[i]), 0);
    end
    full_force = 1'b0;
    repeat (8) step();
    ex_hdr(1); ex_b(8'h40); ex_b(8'h41); ex_b(8'h42); ex_b(8'h43);
    chk_seq("stall_seq");

    // Granted source 2 pauses while source 0 requests.
    clr();
    pend_len[2] = 3; nxt_byte[2] = 8'h50;
    run_until_write(8'h50, "gap");
    gap[2] = 1'b1;
    pend_len[0] = 1; nxt_byte[0] = 8'h60;
    repeat (3) begin
      step();
      chk("gap_gv", int'(h_gv[$]), 1);
      chk("gap_gid", int'(h_gid[$]), 2);
      chk("gap_ready0", int'(h_rdy[$][0]), 0);
    end
    gap[2] = 1'b0;
    repeat (10) step();
    ex_hdr(2); ex_b(8'h50); ex_b(8'h51); ex_b(8'h52); ex_hdr(0); ex_b(8'h60);
    chk_seq("gap_seq");

    // Reset in the middle of a packet.
    clr();
    pend_len[3] = 4; nxt_byte[3] = 8'h30;
    run_until_write(8'h30, "midrst");
    do_reset();
    chk_reset_outputs("midrst");

    // Randomized traffic with random full, valid gaps and occasional reset.
    rnd_mode = 1'b1;
    repeat (3000) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if ((pend_len[i] == 0) && ($urandom_range(0, 3) == 0)) pend_len[i] = $urandom_range(1, 4);
      end
      step();
    end
    rst = 1'b0;
    rnd_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Packet-atomic round-robin arbiter that shares the single UART transmit FIFO among `NUM_SRC` byte-stream producers, such as the result drain, status reporter and debug dump. It sits between the producers and the FIFO write port. It grants one source at a time and holds that grant until the source's last byte is accepted, so packets never interleave on the serial link. An optional header byte carrying the source ID can be inserted ahead of each packet.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 8: byte width; must match the FIFO data width and be ≥ 8.
- `SRC_ID_WIDTH`, localparam = `$clog2(NUM_SRC)`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `src_valid`  in  `NUM_SRC`: source i has a byte on `src_data[i]`.
- `src_data`  in  `NUM_SRC` x `DATA_WIDTH`: per-source byte.
- `src_last`  in  `NUM_SRC`: byte on source i is the final byte of its packet.
- `src_ready`  out  `NUM_SRC`: byte on source i is accepted this cycle when `src_valid[i]` is also high.
- `fifo_we`  out  1: write strobe to the TX FIFO.
- `fifo_w_data`  out  `DATA_WIDTH`: write data to the TX FIFO.
- `fifo_full`  in  1: TX FIFO full flag.
- `grant_valid`  out  1: a packet is in progress.
- `grant_id`  out  `SRC_ID_WIDTH`: currently granted source; holds the last value when idle.

## Operation
- FSM states are `IDLE`, `HDR` and `DATA`.
- **`IDLE`**
  - `src_ready` = 0 and `fifo_we` = 0.
  - If any `src_valid` is high, the arbiter picks the first requester scanning upward from `rr_ptr` with wrap-around.
  - It registers the choice into `grant_id`, sets `grant_valid`, and moves to `HDR` (header enabled) or `DATA`.
  - No byte transfers in `IDLE`.
- **`HDR`**
  - `fifo_we` = `!fifo_full`, with `fifo_w_data` = header byte.
  - The header byte has upper nibble `HEADER_TAG` (4'hA), zero padding in between, and `grant_id` in the low bits. For example, source 2 gives 8'hA2.
  - The arbiter stalls while `fifo_full`, then moves to `DATA` on the write.
- **`DATA`**
  - For the granted source g: `src_ready[g]` = `!fifo_full`, `fifo_we` = `src_valid[g] & !fifo_full`, `fifo_w_data` = `src_data[g]`.
  - All other `src_ready` bits are 0.
  - A transfer with `src_last[g]` high returns the FSM to `IDLE`, clears `grant_valid`, and sets `rr_ptr` to (g+1) mod `NUM_SRC`.
- **Packet atomicity.** If the granted source drops `src_valid` mid-packet, the grant is held indefinitely. No other source can preempt it.
- **Single-byte packet.** A packet whose first data byte has `src_last` set is legal. It completes in one `DATA` cycle.
- **Simultaneous requests.** Among simultaneous requesters, the lowest index at or above `rr_ptr` wins. A new request arriving during a packet waits for `IDLE`.
- **Reset.** Applies in any state, including mid-packet.
  - State returns to `IDLE`, `rr_ptr` = 0, `grant_valid` = 0, `grant_id` = 0.
  - The truncated packet is discarded; the FIFO shares the same reset.

## Timing
- Reset values: `fifo_we` = 0, `fifo_w_data` = 0, `src_ready` = 0, `grant_valid` = 0, `grant_id` = 0.
- `src_ready`, `fifo_we` and `fifo_w_data` are combinational from the state, `grant_id`, `src_valid` and `fifo_full`. There are no combinational paths from `src_data` to control outputs.
- Latency:
  - First valid request to grant: 1 cycle.
  - Grant to header write: same cycle as entering `HDR`.
  - First data byte: the cycle after the header write, or the cycle after grant if the header is compiled out.
- Throughput is 1 byte per cycle in `DATA` while the FIFO is not full.
- Inter-packet overhead:
  - With the header: 1 `IDLE` cycle plus 1 `HDR` cycle.
  - Without the header: 1 `IDLE` cycle.
- `fifo_full` stalls take effect in the same cycle: no write is issued while full.

## Configuration
- Macro: `TX_ARB_HEADER_EN`.
- Defined: the `HDR` state and header byte are present, as described in Operation.
- Undefined:
  - `HDR` is removed and `IDLE` goes directly to `DATA`.
  - Packets are written to the FIFO unframed.
  - `HEADER_TAG` is unused.

## Structure
- Package `tx_arb_pkg` holds:
  - the state enum `tx_arb_state_t` (`IDLE`, `HDR`, `DATA`);
  - `HEADER_TAG` = 4'hA;
  - `MAX_SRC` = 16.
- Sub-module `rr_picker`: combinational rotate, priority-encode and unrotate. Inputs are the request vector and `rr_ptr`; outputs are `pick_valid` and `pick_id`.

## Test plan
- **Lone request.** Reset, then source 1 sends bytes 8'h11, 8'h12, 8'h13, with `last` on 8'h13.
  - FIFO receives 8'hA1, 8'h11, 8'h12, 8'h13 on consecutive cycles.
  - `grant_valid` falls the cycle after 8'h13.
- **All sources at once.** All 4 sources request 2-byte packets simultaneously from reset.
  - Packets are granted in order 0, 1, 2, 3 with no interleaving.
  - The next round starts at source 0.
- **Round-robin fairness.** Source 3 finishes a packet while sources 0 and 3 both request again.
  - Source 0 wins the next grant (`rr_ptr` = 0 after wrap).
- **FIFO full stall.** Assert `fifo_full` for 5 cycles mid-packet.
  - `fifo_we` = 0 and `src_ready` = 0 during the stall.
  - No byte is lost or duplicated after release.
- **Valid gap mid-packet.** Granted source 2 drops `src_valid` for 3 cycles while source 0 requests.
  - Grant stays on source 2 and `src_ready[0]` stays 0.
  - The packet completes intact before source 0 is granted.
- **Reset mid-packet.** Assert `rst` mid-packet and with `TX_ARB_HEADER_EN` undefined.
  - Reset returns all outputs to their reset values the next cycle.
  - With the header undefined, the lone-request stimulus yields only 8'h11, 8'h12, 8'h13.
